// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 core: data width, opcode values, sequencer states.
package mu0_pkg;

  localparam int DATA_W = 16;
  localparam int OPC_W  = 4;
  localparam int S_W    = 12;

  localparam logic [OPC_W-1:0] OP_LDA = 4'd0;
  localparam logic [OPC_W-1:0] OP_STO = 4'd1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'd2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd3;
  localparam logic [OPC_W-1:0] OP_JMP = 4'd4;
  localparam logic [OPC_W-1:0] OP_JGE = 4'd5;
  localparam logic [OPC_W-1:0] OP_JNE = 4'd6;
  localparam logic [OPC_W-1:0] OP_STP = 4'd7;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_OPRD   = 3'd2,
    ST_WB     = 3'd3,
    ST_STORE  = 3'd4,
    ST_HALT   = 3'd5
  } stateT;

endpackage

// File: rtl/mu0_alu.sv
// MU0 arithmetic: accumulator result for LDA/ADD/SUB and jump-taken decision
// for JMP/JGE/JNE. Purely combinational; any other opcode passes the operand
// through and takes no jump.
module mu0_alu
  import mu0_pkg::*;
(
  input  logic [OPC_W-1:0]  op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] result,
  output logic              takeJump
);

  logic signed [DATA_W-1:0] accS;
  logic signed [DATA_W-1:0] operandS;

  assign accS     = acc;
  assign operandS = operand;

  // Result wraps modulo 2^16; JGE treats ACC as two's complement (sign bit clear = taken).
  always_comb begin
    result   = operand;
    takeJump = 1'b0;
    case (op)
      OP_ADD:  result = accS + operandS;
      OP_SUB:  result = accS - operandS;
      OP_JMP:  takeJump = 1'b1;
      OP_JGE:  takeJump = ~accS[DATA_W-1];
      OP_JNE:  takeJump = (acc != '0);
      default: ;
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 fetch/decode/execute sequencer. Owns PC, IR and ACC and drives the
// memory port; hands the port to the debug override only in FETCH or HALT.
// Optional feature: define MU0_SINGLE_STEP_EN to add stepPulse, which gates
// each instruction fetch so exactly one instruction runs per pulse.
module mu0_control
  import mu0_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              stallReq,
`ifdef MU0_SINGLE_STEP_EN
  input  logic              stepPulse,
`endif
  output logic              stallAck,
  output logic              memRq,
  output logic              readNotWrite,
  output logic [15:0]       memAddr,
  output logic [15:0]       memWData,
  input  logic [15:0]       memRData,
  output logic              halted,
  output logic [15:0]       accOut,
  output logic [ADDR_W-1:0] pcOut
);

  stateT             state;
  stateT             stateNext;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcNext;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] irNext;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] accNext;

  logic [OPC_W-1:0]  aluOp;
  logic [DATA_W-1:0] aluResult;
  logic              aluTake;
  logic              fetchGo;
  logic [ADDR_W-1:0] decS;
  logic [ADDR_W-1:0] irS;

  // Operand field of the word arriving from memory (DECODE) and of the latched IR.
  assign decS = ADDR_W'(memRData[S_W-1:0]);
  assign irS  = ADDR_W'(ir[S_W-1:0]);

  // In DECODE the instruction is still on memRData, so jump decisions use it directly.
  assign aluOp = (state == ST_DECODE) ? memRData[DATA_W-1:S_W] : ir[DATA_W-1:S_W];

`ifdef MU0_SINGLE_STEP_EN
  assign fetchGo = ~stallReq & stepPulse;
`else
  assign fetchGo = ~stallReq;
`endif

  mu0_alu uAlu (
    .op       (aluOp),
    .acc      (acc),
    .operand  (memRData),
    .result   (aluResult),
    .takeJump (aluTake)
  );

  // State and architectural registers; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state <= ST_FETCH;
      pc    <= ADDR_W'(RESET_PC);
      ir    <= '0;
      acc   <= '0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      ir    <= irNext;
      acc   <= accNext;
    end
  end

  // Next-state, register updates and memory-port drive for the current state.
  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    irNext       = ir;
    accNext      = acc;
    memRq        = 1'b0;
    readNotWrite = 1'b1;
    memAddr      = '0;
    memWData     = '0;
    stallAck     = 1'b0;
    halted       = 1'b0;

    case (state)
      ST_FETCH: begin
        stallAck = stallReq;
        if (fetchGo) begin
          memRq     = 1'b1;
          memAddr   = 16'(pc);
          stateNext = ST_DECODE;
        end
      end
      ST_DECODE: begin
        irNext    = memRData;
        pcNext    = pc + ADDR_W'(1);
        stateNext = ST_FETCH;
        case (memRData[DATA_W-1:S_W])
          OP_LDA, OP_ADD, OP_SUB: stateNext = ST_OPRD;
          OP_STO:                 stateNext = ST_STORE;
          OP_JMP, OP_JGE, OP_JNE: if (aluTake) pcNext = decS;
          OP_STP:                 stateNext = ST_HALT;
          default:                ;
        endcase
      end
      ST_OPRD: begin
        memRq     = 1'b1;
        memAddr   = 16'(irS);
        stateNext = ST_WB;
      end
      ST_WB: begin
        accNext   = aluResult;
        stateNext = ST_FETCH;
      end
      ST_STORE: begin
        memRq        = 1'b1;
        readNotWrite = 1'b0;
        memAddr      = 16'(irS);
        memWData     = acc;
        stateNext    = ST_FETCH;
      end
      ST_HALT: begin
        halted   = 1'b1;
        stallAck = stallReq;
      end
      default: stateNext = ST_FETCH;
    endcase

    // Keep the port idle while reset is asserted so an abandoned STO never writes.
    if (!rstN) begin
      memRq        = 1'b0;
      readNotWrite = 1'b1;
      memAddr      = '0;
      memWData     = '0;
      stallAck     = 1'b0;
      halted       = 1'b0;
    end
  end

  assign accOut = acc;
  assign pcOut  = pc;

endmodule

// File: tb/tb_mu0_control.sv
// Bench for mu0_control: directed scenarios followed by random programs,
// each instruction checked against an instruction-level model of MU0.
module tb_mu0_control;

  logic        clk = 1'b0;
  logic        rstN;
  logic        stallReq;
  logic        stallAck;
  logic        memRq;
  logic        readNotWrite;
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic [15:0] memRData = 16'h0000;
  logic        halted;
  logic [15:0] accOut;
  logic [11:0] pcOut;
`ifdef MU0_SINGLE_STEP_EN
  logic        stepPulse;
  bit          stepOnce = 1'b0;
`endif

  logic [15:0] mem    [0:4095];
  logic [15:0] image  [0:4095];
  logic [15:0] refMem [0:4095];
  logic        loadReq;

  logic [11:0] mPc;
  logic [15:0] mAcc;
  bit          mHalted;

  int nAssert = 0;
  int nFail   = 0;

  mu0_control #(.ADDR_W(12), .RESET_PC(0)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .stallReq     (stallReq),
`ifdef MU0_SINGLE_STEP_EN
    .stepPulse    (stepPulse),
`endif
    .stallAck     (stallAck),
    .memRq        (memRq),
    .readNotWrite (readNotWrite),
    .memAddr      (memAddr),
    .memWData     (memWData),
    .memRData     (memRData),
    .halted       (halted),
    .accOut       (accOut),
    .pcOut        (pcOut)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after the request, writes commit at the edge.
  always @(posedge clk) begin
    if (loadReq) begin
      for (int i = 0; i < 4096; i++) mem[i] <= image[i];
    end else if (memRq) begin
      if (readNotWrite) memRData <= mem[memAddr[11:0]];
      else              mem[memAddr[11:0]] <= memWData;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, observed no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nAssert++;
    assert (got === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic setWord(input logic [11:0] a, input logic [15:0] v);
    image[a]  = v;
    refMem[a] = v;
  endtask

  task automatic clearImage();
    for (int i = 0; i < 4096; i++) begin
      image[i]  = 16'h0000;
      refMem[i] = 16'h0000;
    end
  endtask

  // One reset cycle, with stallReq high to show stallAck stays low under reset.
  task automatic doReset(input bit load);
    rstN     = 1'b0;
    stallReq = 1'b1;
    loadReq  = load;
    #1;
    chk("rst_memRq_during", memRq, 0);
    chk("rst_stallAck_during", stallAck, 0);
    @(negedge clk);
    loadReq = 1'b0;
    chk("rst_pc", pcOut, 0);
    chk("rst_acc", accOut, 0);
    chk("rst_halted", halted, 0);
    chk("rst_memRq", memRq, 0);
    chk("rst_rnw", readNotWrite, 1);
    chk("rst_addr", memAddr, 0);
    chk("rst_wdata", memWData, 0);
    chk("rst_stallAck", stallAck, 0);
    rstN     = 1'b1;
    stallReq = 1'b0;
    mPc      = 12'h000;
    mAcc     = 16'h0000;
    mHalted  = 1'b0;
    #1;
  endtask

  // Hold the port from FETCH for n cycles, then release it.
  task automatic stallHold(input int n);
    stallReq = 1'b1;
    #1;
    for (int k = 0; k < n; k++) begin
      chk("hold_stallAck", stallAck, 1);
      chk("hold_memRq", memRq, 0);
      @(negedge clk);
    end
    chk("hold_pc", pcOut, mPc);
    stallReq = 1'b0;
    #1;
  endtask

  // Execute one instruction in the model and check the DUT cycle by cycle.
  // stallAt >= 1 raises stallReq during that cycle of the instruction.
  task automatic runInstr(input int stallAt);
    logic [15:0] instr;
    logic [15:0] accBefore;
    logic [15:0] expAcc;
    logic [11:0] pcBefore;
    logic [11:0] expPc;
    logic [11:0] s;
    logic [3:0]  op;
    int          lat;
    pcBefore  = mPc;
    accBefore = mAcc;
    instr     = refMem[mPc];
    op        = instr[15:12];
    s         = instr[11:0];
    expPc     = mPc + 12'd1;
    expAcc    = mAcc;
    lat       = 2;
    case (op)
      4'd0: begin expAcc = refMem[s];        lat = 4; end
      4'd1: begin refMem[s] = mAcc;          lat = 3; end
      4'd2: begin expAcc = mAcc + refMem[s]; lat = 4; end
      4'd3: begin expAcc = mAcc - refMem[s]; lat = 4; end
      4'd4: expPc = s;
      4'd5: if ($signed(mAcc) >= 0) expPc = s;
      4'd6: if (mAcc != 0) expPc = s;
      4'd7: mHalted = 1'b1;
      default: ;
    endcase

    for (int c = 0; c < lat; c++) begin
      if (c == stallAt) begin
        stallReq = 1'b1;
        #1;
        chk("inflight_stallAck", stallAck, 0);
      end
      chk("memRq_pattern", memRq, (c % 2 == 0));
      if (c == 0) chk("fetch_addr", memAddr, {4'h0, pcBefore});
      if (c == 2) begin
        chk("operand_addr", memAddr, {4'h0, s});
        chk("rnw_c2", readNotWrite, (op != 4'd1));
        if (op == 4'd1) chk("sto_wdata", memWData, accBefore);
      end
      if (c % 2 == 1) chk("rnw_idle", readNotWrite, 1);
      @(negedge clk);
`ifdef MU0_SINGLE_STEP_EN
      if (stepOnce) begin
        stepPulse = 1'b0;
        stepOnce  = 1'b0;
        #1;
      end
`endif
    end

    mPc  = expPc;
    mAcc = expAcc;
    chk("pc", pcOut, mPc);
    chk("acc", accOut, mAcc);
    chk("halted", halted, mHalted);
    if (mHalted) chk("halt_memRq", memRq, 0);
    if (op == 4'd1) chk("sto_mem", mem[s], refMem[s]);

    if (stallReq) begin
      for (int k = 0; k < 2; k++) begin
        chk("post_stallAck", stallAck, 1);
        chk("post_memRq", memRq, 0);
        @(negedge clk);
      end
      chk("post_pc", pcOut, mPc);
      stallReq = 1'b0;
      #1;
    end
  endtask

  initial begin
    logic [15:0] w;
    int          sa;
    rstN     = 1'b0;
    stallReq = 1'b0;
    loadReq  = 1'b0;
`ifdef MU0_SINGLE_STEP_EN
    stepPulse = 1'b1;
`endif

    // Scenario 1: LDA 5 from reset.
    clearImage();
    setWord(12'h000, 16'h0005);
    setWord(12'h005, 16'h1234);
    doReset(1'b1);
    runInstr(-1);
    chk("t1_acc", accOut, 16'h1234);
    chk("t1_pc", pcOut, 12'h001);

    // Scenarios 2-5 as one program.
    clearImage();
    setWord(12'h000, 16'h0100);  // LDA 0x100
    setWord(12'h001, 16'h2101);  // ADD 0x101
    setWord(12'h002, 16'h5010);  // JGE 0x010
    setWord(12'h003, 16'h6010);  // JNE 0x010
    setWord(12'h010, 16'h0102);  // LDA 0x102
    setWord(12'h011, 16'h1020);  // STO 0x020
    setWord(12'h012, 16'h2103);  // ADD 0x103
    setWord(12'h013, 16'h0104);  // LDA 0x104
    setWord(12'h014, 16'h1000);  // STO 0x000
    setWord(12'h015, 16'h4FFF);  // JMP 0xFFF
    setWord(12'hFFF, 16'h8000);  // NOP
    setWord(12'h100, 16'h7FFF);
    setWord(12'h101, 16'h0001);
    setWord(12'h102, 16'hBEEF);
    setWord(12'h103, 16'h0001);
    setWord(12'h104, 16'h7000);  // STP pattern
    doReset(1'b1);
    runInstr(-1);
    runInstr(-1);
    chk("t2_add_acc", accOut, 16'h8000);
    runInstr(-1);
    chk("t2_jge_pc", pcOut, 12'h003);
    runInstr(-1);
    chk("t2_jne_pc", pcOut, 12'h010);
    runInstr(-1);
    runInstr(-1);
    chk("t3_mem", mem[12'h020], 16'hBEEF);
    runInstr(1);
    chk("t4_acc", accOut, 16'hBEF0);
    runInstr(-1);
    runInstr(-1);
    runInstr(-1);
    runInstr(-1);
    chk("t5_wrap_pc", pcOut, 12'h000);
    runInstr(-1);
    chk("t5_halted", halted, 1);
    for (int k = 0; k < 3; k++) begin
      chk("t5_halt_memRq", memRq, 0);
      @(negedge clk);
    end
    stallReq = 1'b1;
    #1;
    chk("t5_halt_stallAck", stallAck, 1);
    stallReq = 1'b0;
    #1;
    chk("t5_halt_noAck", stallAck, 0);
    doReset(1'b0);
    chk("t5_reset_pc", pcOut, 12'h000);

`ifdef MU0_SINGLE_STEP_EN
    // Scenario 6: single step.
    clearImage();
    setWord(12'h000, 16'h0005);
    setWord(12'h001, 16'h0005);
    setWord(12'h005, 16'h1234);
    stepPulse = 1'b0;
    doReset(1'b1);
    for (int k = 0; k < 10; k++) begin
      chk("t6_idle_memRq", memRq, 0);
      @(negedge clk);
    end
    stepPulse = 1'b1;
    stepOnce  = 1'b1;
    #1;
    runInstr(-1);
    chk("t6_acc", accOut, 16'h1234);
    for (int k = 0; k < 5; k++) begin
      chk("t6_after_memRq", memRq, 0);
      @(negedge clk);
    end
    chk("t6_pc", pcOut, 12'h001);
    stepPulse = 1'b1;
    #1;
`endif

    // Random programs against the instruction-level model.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4096; i++) begin
        w         = 16'($urandom);
        image[i]  = w;
        refMem[i] = w;
      end
      doReset(1'b1);
      for (int n = 0; n < 250; n++) begin
        if ($urandom_range(0, 7) == 0) stallHold(int'($urandom_range(1, 3)));
        sa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : -1;
        runInstr(sa);
        if (mHalted) doReset(1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
